switch_debounce: RTL
====================

// Module: switch_debounce
// PURPOSE
//   Conditions the four raw board switches before they reach the switch-to-LED
//   combinational logic. Each input is synchronised, debounced by a
//   stable-duration counter, and presented as a clean level. A single-cycle
//   edge pulse is also produced for any consumer that counts presses.
//   Sits between the top-level pins and the switch logic block.
// PARAMETERS
//   NUM_SW           4       number of independent switch channels
//   DEBOUNCE_CYCLES  250000  consecutive cycles a new level must hold (10 ms @ 25 MHz); legal >= 2
//   CNT_W            $clog2(DEBOUNCE_CYCLES)  counter width (derived, do not override)
// PORTS
//   i_clk       in   1       system clock, all logic on rising edge
//   i_rst_n     in   1       asynchronous, active-low reset
//   i_switch    in   NUM_SW  raw, asynchronous, bouncing switch levels
//   o_switch    out  NUM_SW  debounced level, registered
//   o_rise      out  NUM_SW  1-cycle pulse: o_switch[n] just went 0->1
//   o_fall      out  NUM_SW  1-cycle pulse: o_switch[n] just went 1->0
// BEHAVIOUR
//   - Reset (i_rst_n=0, async assert, sync-to-clock deassert by board): sync flops,
//     counters, o_switch, o_rise, o_fall all 0.
//   - Per channel, independent, no shared state:
//     * 2-flop synchroniser: sync1 <= i_switch[n]; sync2 <= sync1.
//     * sync2 == stable: count <= 0 (any bounce back restarts the window).
//     * sync2 != stable, count <  DEBOUNCE_CYCLES-1: count <= count+1.
//     * sync2 != stable, count == DEBOUNCE_CYCLES-1: stable <= sync2, count <= 0,
//       o_rise[n]/o_fall[n] <= 1 per new value; else pulses <= 0.
//   - o_switch[n] = stable (direct flop output, no combinational path from i_switch).
//   - Latency: new level first sampled into sync1 at edge 0 and held clean ->
//     o_switch changes at edge DEBOUNCE_CYCLES+1; pulse high for exactly the cycle
//     following that edge, same cycle o_switch first shows the new value.
//   - A level held < DEBOUNCE_CYCLES cycles at sync2 never propagates; no pulse.
//   - Counter never wraps: it is cleared on accept or on match, max DEBOUNCE_CYCLES-1.
//   - Simultaneous changes on several channels resolve independently; identical
//     timing gives identical update edges and multi-bit pulse vectors.
//   - Switch held at 1 through reset release: o_switch rises DEBOUNCE_CYCLES+1 edges
//     after first sample, with an o_rise pulse (reset state is treated as 0).
//   - Reset mid-count: count discarded; full window restarts after release.
// STRUCTURE
//   - switch_pkg: SW_NUM_DEFAULT=4, SW_DEBOUNCE_DEFAULT=250000,
//     SW_DEBOUNCE_SIM=8 (bench value).
//   - Sub-module debounce_channel (synchroniser + counter + stable + pulse flops,
//     params DEBOUNCE_CYCLES/CNT_W); switch_debounce is a generate loop of NUM_SW
//     instances plus port bundling.
// TESTING  (DEBOUNCE_CYCLES=8, NUM_SW=4)
//   1 Reset, i_switch=4'h0 for 50 cycles -> o_switch=0, o_rise=o_fall=0 throughout.
//   2 i_switch[0] 0->1 clean, sampled edge 0 -> o_switch[0]=1 from edge 9;
//     o_rise=4'h1 for exactly one cycle; other bits unchanged.
//   3 i_switch[1] toggles every 3 cycles for 30 cycles then held 1 -> o_switch[1]
//     stays 0 while bouncing; rises 9 edges after last transition sampled; one o_rise.
//   4 i_switch[2] high 7 cycles then low -> o_switch[2] never changes, no pulses.
//   5 All switches stable 1, then 4'hF->4'h0 same cycle -> all o_switch bits fall
//     on same edge; o_fall=4'hF for one cycle, o_rise=0.
//   6 i_rst_n low while channel 3 count=5 -> outputs 0 immediately (async); release
//     with i_switch[3]=1 -> o_switch[3] rises 9 edges after first sample, one o_rise.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared defaults and the per-channel output bundle for the switch conditioning block.
package switch_pkg;

    localparam int SW_NUM_DEFAULT      = 4;
    localparam int SW_DEBOUNCE_DEFAULT = 250000;  // 10 ms at 25 MHz
    localparam int SW_DEBOUNCE_SIM     = 8;       // short window for simulation

    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
    } sw_out_t;

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: 2-flop synchroniser, stable-duration counter, clean level
// and single-cycle edge pulses, all registered.
module debounce_channel
    import switch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic    i_clk,
    input  logic    i_rst_n,
    input  logic    i_switch,
    output sw_out_t o_chan
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        // NOTE: every _d gets a default first, so no path can infer a latch.
        sync1_d  = i_switch;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        count_d  = '0;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        // Counter only runs while the synchronised level disagrees with the accepted one.
        if (sync2_q != stable_q) begin
            if (count_q == CNT_MAX) begin
                stable_d = sync2_q;
                rise_d   = sync2_q;
                fall_d   = ~sync2_q;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (!i_rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            count_q  <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            count_q  <= count_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign o_chan = '{level: stable_q, rise: rise_q, fall: fall_q};

endmodule

// File: rtl/switch_debounce.sv
// Debounces NUM_SW raw board switches into clean levels plus rise/fall pulses;
// channels are fully independent.
module switch_debounce
    import switch_pkg::*;
#(
    parameter int NUM_SW          = SW_NUM_DEFAULT,
    parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NUM_SW-1:0] i_switch,
    output logic [NUM_SW-1:0] o_switch,
    output logic [NUM_SW-1:0] o_rise,
    output logic [NUM_SW-1:0] o_fall
);

    for (genvar n = 0; n < NUM_SW; n++) begin : g_chan
        sw_out_t chan;

        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_chan (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_switch(i_switch[n]),
            .o_chan  (chan)
        );

        assign o_switch[n] = chan.level;
        assign o_rise[n]   = chan.rise;
        assign o_fall[n]   = chan.fall;
    end

endmodule
